// File: rtl/eee_imgproc_spi_slave.sv
// SPI mode-0 slave: exports buffered 32-bit result words on MISO and returns
// received 32-bit MOSI command words. All SPI pins are oversampled in the clk domain.
module eee_imgproc_spi_slave #(
   parameter int          DEPTH       = 16,
   parameter logic [31:0] IDLE_WORD   = 32'h0000_0000,
   parameter int          SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic [31:0]                in_data,
   output logic                       in_ready,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic                       rx_valid,
   output logic [31:0]                rx_data,
   output logic                       frame_abort,
   input  logic                       spi_clk,
   input  logic                       spi_cs_n,
   input  logic                       spi_mosi,
   output logic                       spi_miso
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                 state, state_next;
   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
   logic                   sclk_d, cs_d;
   logic                   sclk_s, cs_s, mosi_s;
   logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic [31:0]            mem [DEPTH];
   logic [AW-1:0]          wr_ptr, rd_ptr;
   logic [LW-1:0]          count;
   logic                   push, pop, load;
   logic [31:0]            tx_shift, rx_shift;
   logic [5:0]             bit_cnt;
   logic                   load_pending;

   // Synchronisers reset to the inactive pin levels so reset never fakes an edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sclk_d    <= 1'b0;
         cs_d      <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         sclk_d    <= sclk_s;
         cs_d      <= cs_s;
      end
   end

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign cs_fall   = ~cs_s & cs_d;
   assign cs_rise   = cs_s & ~cs_d;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // cs_rise outranks any sclk edge seen in the same cycle.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      case (state)
         IDLE: begin
            if (cs_fall) begin
               load       = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (cs_rise)                        state_next = IDLE;
            else if (sclk_fall && load_pending) load = 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

   // Pop decision uses the pre-push level, so a same-cycle push is never bypassed.
   assign in_ready   = (count != FULL_LVL);
   assign fifo_level = count;
   assign push       = in_valid && in_ready;
   assign pop        = load && (count != '0);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_shift     <= '0;
         rx_shift     <= '0;
         bit_cnt      <= '0;
         load_pending <= 1'b0;
         rx_valid     <= 1'b0;
         rx_data      <= '0;
         frame_abort  <= 1'b0;
         spi_miso     <= 1'b0;
      end else begin
         rx_valid    <= 1'b0;
         frame_abort <= 1'b0;
         spi_miso    <= (state == SHIFT) ? tx_shift[31] : 1'b0;

         if (load)
            tx_shift <= (count != '0) ? mem[rd_ptr] : IDLE_WORD;
         else if (state == SHIFT && !cs_rise && sclk_fall)
            tx_shift <= {tx_shift[30:0], 1'b0};

         if (state == IDLE) begin
            bit_cnt      <= '0;
            load_pending <= 1'b0;
         end else if (cs_rise) begin
            if (bit_cnt != '0) frame_abort <= 1'b1;
            bit_cnt      <= '0;
            rx_shift     <= '0;
            load_pending <= 1'b0;
         end else begin
            if (bit_cnt == 6'd32) begin
               rx_data      <= rx_shift;
               rx_valid     <= 1'b1;
               bit_cnt      <= '0;
               load_pending <= 1'b1;
            end else if (sclk_rise) begin
               rx_shift <= {rx_shift[30:0], mosi_s};
               bit_cnt  <= bit_cnt + 6'd1;
            end
            if (sclk_fall && load_pending) load_pending <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_eee_imgproc_spi_slave.sv
// Bench for eee_imgproc_spi_slave: a bit-banged SPI master plus a queue model
// of the result FIFO and of the expected received command words.
module tb_eee_imgproc_spi_slave;

   localparam int          DEPTH     = 16;
   localparam logic [31:0] IDLE_WORD = 32'h0000_0000;
   localparam int          LW        = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic [31:0]   in_data = '0;
   logic          in_ready;
   logic [LW-1:0] fifo_level;
   logic          rx_valid;
   logic [31:0]   rx_data;
   logic          frame_abort;
   logic          spi_clk = 1'b0;
   logic          spi_cs_n = 1'b1;
   logic          spi_mosi = 1'b0;
   logic          spi_miso;

   int pass_cnt = 0;
   int total_cnt = 0;
   int abort_cnt = 0;
   int half = 8;

   logic [31:0] model_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] rx_seen[$];
   logic [31:0] mosi_words [0:15];
   logic [31:0] miso_words [0:15];

   eee_imgproc_spi_slave #(.DEPTH(DEPTH), .IDLE_WORD(IDLE_WORD), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .fifo_level(fifo_level), .rx_valid(rx_valid),
      .rx_data(rx_data), .frame_abort(frame_abort), .spi_clk(spi_clk),
      .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!reset) begin
         if (rx_valid) rx_seen.push_back(rx_data);
         if (frame_abort) abort_cnt++;
      end
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_word(input logic [31:0] w);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = w;
      @(negedge clk);
      in_valid = 1'b0;
      model_q.push_back(w);
   endtask

   // Mode-0 master. Ends with sclk high and raises cs before returning sclk low,
   // so no trailing falling edge is seen inside the frame.
   task automatic run_frame(input int nbits);
      int w, k;
      @(negedge clk);
      spi_cs_n = 1'b0;
      for (int b = 0; b < nbits; b++) begin
         w = b / 32;
         k = 31 - (b % 32);
         spi_mosi = mosi_words[w][k];
         wait_clks(half);
         miso_words[w][k] = spi_miso;
         spi_clk = 1'b1;
         wait_clks(half);
         if (b != nbits - 1) spi_clk = 1'b0;
      end
      spi_cs_n = 1'b1;
      wait_clks(4);
      spi_clk = 1'b0;
      wait_clks(8);
   endtask

   function automatic logic [31:0] model_pop();
      if (model_q.size() != 0) return model_q.pop_front();
      return IDLE_WORD;
   endfunction

   task automatic test_reset();
      total_cnt++; if (fifo_level !== '0) $display("FAIL reset_level: got %0d want 0", fifo_level); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready); else pass_cnt++;
      total_cnt++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b want 0", rx_valid); else pass_cnt++;
      total_cnt++; if (rx_data !== '0) $display("FAIL reset_rx_data: got %h want 0", rx_data); else pass_cnt++;
      total_cnt++; if (frame_abort !== 1'b0) $display("FAIL reset_abort: got %b want 0", frame_abort); else pass_cnt++;
      total_cnt++; if (spi_miso !== 1'b0) $display("FAIL reset_miso: got %b want 0", spi_miso); else pass_cnt++;
   endtask

   task automatic test_single_frame();
      logic [31:0] exp_tx;
      push_word(32'hA5A5_0F0F);
      total_cnt++; if (fifo_level !== LW'(1)) $display("FAIL single_level_pre: got %0d want 1", fifo_level); else pass_cnt++;
      mosi_words[0] = 32'h1234_5678;
      rx_seen.delete();
      exp_tx = model_pop();
      run_frame(32);
      total_cnt++; if (miso_words[0] !== exp_tx) $display("FAIL single_miso: got %h want %h", miso_words[0], exp_tx); else pass_cnt++;
      total_cnt++; if (rx_seen.size() !== 1) $display("FAIL single_rx_count: got %0d want 1", rx_seen.size()); else pass_cnt++;
      if (rx_seen.size() == 1) begin
         total_cnt++; if (rx_seen[0] !== 32'h1234_5678) $display("FAIL single_rx_data: got %h want 12345678", rx_seen[0]); else pass_cnt++;
      end
      total_cnt++; if (fifo_level !== '0) $display("FAIL single_level_post: got %0d want 0", fifo_level); else pass_cnt++;
   endtask

   task automatic test_empty_frame();
      logic [31:0] exp_tx;
      mosi_words[0] = $urandom;
      rx_seen.delete();
      exp_tx = model_pop();
      run_frame(32);
      total_cnt++; if (miso_words[0] !== exp_tx) $display("FAIL empty_miso: got %h want %h", miso_words[0], exp_tx); else pass_cnt++;
      total_cnt++; if (fifo_level !== '0) $display("FAIL empty_level: got %0d want 0", fifo_level); else pass_cnt++;
      total_cnt++; if (rx_seen.size() !== 1) $display("FAIL empty_rx_count: got %0d want 1", rx_seen.size()); else pass_cnt++;
      if (rx_seen.size() == 1) begin
         total_cnt++; if (rx_seen[0] !== mosi_words[0]) $display("FAIL empty_rx_data: got %h want %h", rx_seen[0], mosi_words[0]); else pass_cnt++;
      end
   endtask

   // Shared by the fixed 3-word burst and the randomised bursts.
   task automatic burst_and_check(input int nwords, input string tag);
      logic [31:0] exp_tx [0:15];
      exp_q.delete();
      rx_seen.delete();
      for (int i = 0; i < nwords; i++) begin
         mosi_words[i] = $urandom;
         exp_q.push_back(mosi_words[i]);
         exp_tx[i] = model_pop();
      end
      run_frame(nwords * 32);
      for (int i = 0; i < nwords; i++) begin
         total_cnt++; if (miso_words[i] !== exp_tx[i]) $display("FAIL %s_miso[%0d]: got %h want %h", tag, i, miso_words[i], exp_tx[i]); else pass_cnt++;
      end
      total_cnt++; if (rx_seen.size() !== nwords) $display("FAIL %s_rx_count: got %0d want %0d", tag, rx_seen.size(), nwords); else pass_cnt++;
      for (int i = 0; i < nwords && i < rx_seen.size(); i++) begin
         total_cnt++; if (rx_seen[i] !== exp_q[i]) $display("FAIL %s_rx[%0d]: got %h want %h", tag, i, rx_seen[i], exp_q[i]); else pass_cnt++;
      end
      total_cnt++; if (fifo_level !== LW'(model_q.size())) $display("FAIL %s_level: got %0d want %0d", tag, fifo_level, model_q.size()); else pass_cnt++;
   endtask

   task automatic test_burst();
      push_word(32'd1);
      push_word(32'd2);
      push_word(32'd3);
      burst_and_check(3, "burst");
   endtask

   task automatic test_full();
      logic exp_ready;
      @(negedge clk);
      in_valid = 1'b1;
      for (int i = 0; i < DEPTH + 2; i++) begin
         in_data   = $urandom;
         exp_ready = (model_q.size() < DEPTH);
         total_cnt++; if (in_ready !== exp_ready) $display("FAIL full_ready[%0d]: got %b want %b", i, in_ready, exp_ready); else pass_cnt++;
         if (exp_ready) model_q.push_back(in_data);
         @(negedge clk);
      end
      in_valid = 1'b0;
      total_cnt++; if (fifo_level !== LW'(DEPTH)) $display("FAIL full_level: got %0d want %0d", fifo_level, DEPTH); else pass_cnt++;
      burst_and_check(1, "full_pop");
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL full_ready_after: got %b want 1", in_ready); else pass_cnt++;
      burst_and_check(DEPTH - 1, "full_drain");
   endtask

   task automatic test_abort();
      int ab0;
      logic [31:0] exp_tx;
      push_word($urandom);
      push_word($urandom);
      mosi_words[0] = $urandom;
      rx_seen.delete();
      ab0 = abort_cnt;
      void'(model_pop());
      run_frame(13);
      total_cnt++; if (abort_cnt - ab0 !== 1) $display("FAIL abort_pulse: got %0d want 1", abort_cnt - ab0); else pass_cnt++;
      total_cnt++; if (rx_seen.size() !== 0) $display("FAIL abort_rx: got %0d want 0", rx_seen.size()); else pass_cnt++;
      total_cnt++; if (spi_miso !== 1'b0) $display("FAIL abort_idle_miso: got %b want 0", spi_miso); else pass_cnt++;
      exp_tx = model_q[0];
      burst_and_check(1, "after_abort");
      total_cnt++; if (miso_words[0] !== exp_tx) $display("FAIL abort_next_word: got %h want %h", miso_words[0], exp_tx); else pass_cnt++;
      total_cnt++; if (abort_cnt - ab0 !== 1) $display("FAIL abort_no_extra: got %0d want 1", abort_cnt - ab0); else pass_cnt++;
   endtask

   task automatic test_reset_mid_frame();
      push_word(32'hFFFF_FFFF);
      push_word(32'hFFFF_FFFF);
      half = 4;
      @(negedge clk);
      spi_cs_n = 1'b0;
      wait_clks(8);
      for (int i = 0; i < 5; i++) begin
         spi_clk = 1'b1;
         wait_clks(half);
         if (i != 4) begin
            spi_clk = 1'b0;
            wait_clks(half);
         end
      end
      reset = 1'b1;
      @(negedge clk);
      test_reset();
      spi_cs_n = 1'b1;
      spi_clk  = 1'b0;
      model_q.delete();
      wait_clks(6);
      reset = 1'b0;
      wait_clks(4);
      half = 8;
      push_word($urandom);
      burst_and_check(1, "post_reset");
   endtask

   task automatic test_random_bursts();
      int npush, nwords;
      for (int it = 0; it < 4; it++) begin
         npush  = $urandom_range(0, 3);
         nwords = $urandom_range(1, 3);
         for (int j = 0; j < npush; j++) push_word($urandom);
         burst_and_check(nwords, "rand");
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         mosi_words[i] = '0;
         miso_words[i] = '0;
      end
      reset = 1'b1;
      wait_clks(4);
      test_reset();
      reset = 1'b0;
      wait_clks(4);
      test_single_frame();
      test_empty_frame();
      test_burst();
      test_full();
      test_abort();
      test_random_bursts();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/eee_imgproc_spi_slave.md
Name: eee_imgproc_spi_slave

Overview:
- SPI slave (mode 0, MSB first, 32-bit words) that exports image-processing results to an external microcontroller and receives 32-bit command words from it.
- Sits directly downstream of the eee_imgproc result generator. Buffers its result words in a FIFO and drives the spi_miso pin of the system's SPI conduit.
- Received MOSI words are returned to eee_imgproc for mode and threshold control.
- All SPI pins are asynchronous to clk. They are synchronised and oversampled in the clk domain.

Parameters:
- DEPTH, 16, result FIFO depth in words. Must be a power of 2 and at least 2.
- IDLE_WORD, 32'h0000_0000, word shifted out when the FIFO is empty at word load.
- SYNC_STAGES, 2, synchroniser flops on spi_clk, spi_cs_n and spi_mosi. Minimum 2.

Ports:
- clk  in  1  system clock. Must be at least 8x the spi_clk frequency.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  result word valid from the imgproc core.
- in_data  in  32  result word.
- in_ready  out  1  FIFO can accept a word. Equals !full.
- fifo_level  out  $clog2(DEPTH)+1  number of words currently stored.
- rx_valid  out  1  one-cycle pulse: a complete MOSI word is available.
- rx_data  out  32  last complete MOSI word. Held until the next rx_valid.
- frame_abort  out  1  one-cycle pulse: spi_cs_n deasserted mid-word.
- spi_clk  in  1  SPI clock from the master.
- spi_cs_n  in  1  SPI chip select, active low.
- spi_mosi  in  1  master-out data.
- spi_miso  out  1  slave-out data.

Behaviour:
- Reset values:
  - FIFO empty; fifo_level=0; in_ready=1.
  - rx_valid=0, rx_data=0, frame_abort=0, spi_miso=0.
  - State = IDLE; bit_cnt=0; shift registers=0.
  - Synchroniser flops are set to their inactive levels: cs_n=1, clk=0, mosi=0.
- Synchronisation and edge detection:
  - Each SPI input passes through SYNC_STAGES flops, then one extra flop for edge detection.
  - sclk_rise, sclk_fall, cs_fall and cs_rise are single-cycle strobes.
  - SPI-edge-to-action latency is SYNC_STAGES+1 clk cycles.
- FIFO:
  - Push when in_valid && in_ready. Pop only at a word load (see below).
  - Simultaneous push and pop: fifo_level is unchanged; data order is preserved.
  - No bypass: a word pushed in the same cycle as a load on an empty FIFO is not sent. IDLE_WORD is sent instead, and the pushed word is stored.
  - Pointers wrap modulo DEPTH. fifo_level never exceeds DEPTH.
- State IDLE (cs high):
  - spi_miso=0.
  - On cs_fall: perform a word load, clear bit_cnt, go to SHIFT.
- Word load:
  - tx_shift <= FIFO head and pop if the FIFO is non-empty; otherwise tx_shift <= IDLE_WORD.
  - spi_miso = tx_shift[31], registered. It is valid 1 clk after the load.
- State SHIFT:
  - On sclk_rise: rx_shift <= {rx_shift[30:0], mosi_sync}; bit_cnt++.
  - When bit_cnt reaches 32 on sclk_rise:
    - Next cycle: rx_data <= assembled word, rx_valid=1 for one cycle, bit_cnt <= 0.
    - Set the flag load_pending.
  - On sclk_fall:
    - If load_pending: perform a word load (burst continues) and clear load_pending.
    - Otherwise: tx_shift <= {tx_shift[30:0], 1'b0}.
  - On cs_rise: return to IDLE.
    - If bit_cnt != 0: pulse frame_abort for one cycle and discard the partial rx_shift; no rx_valid.
    - A word already popped is consumed and not re-sent.
- Ordering and priority:
  - sclk edges are ignored while in IDLE.
  - cs_rise and an sclk edge in the same cycle: cs_rise wins, and the edge is ignored.
- Reset mid-transfer forces IDLE immediately. The master must deassert and reassert spi_cs_n before the next frame.

Test Plan:
1. Push 32'hA5A5_0F0F, then run one 32-bit frame with MOSI=32'h1234_5678.
   - MISO captured on the master's rising edges = A5A5_0F0F.
   - rx_valid pulses once with rx_data=1234_5678.
   - fifo_level goes 1 -> 0.
2. Empty FIFO, one frame.
   - MISO = IDLE_WORD (all zeros).
   - fifo_level stays 0; rx_valid pulses once.
3. Push 3 words (1, 2, 3); hold cs low for a 96-clock burst.
   - MISO sequence = 1, 2, 3.
   - Three rx_valid pulses; fifo_level ends at 0.
4. Push DEPTH+2 words with in_valid held high.
   - in_ready drops after DEPTH accepts; fifo_level=DEPTH.
   - A subsequent frame pops one word; in_ready returns to 1.
5. Deassert cs_n after 13 sclk cycles.
   - frame_abort pulses once; no rx_valid.
   - The next frame shifts the next FIFO word, not the aborted one.
6. Assert reset mid-frame with spi_clk at clk/8.
   - All outputs return to their reset values the next cycle.
   - The next full cs frame transfers correctly.
